// File: rtl/mat_vec_loader.sv
// Memory-side producer for the 8x8 matrix-vector unit. It fetches eight A rows
// and the b word, then writes them column by column into the unit's FIFOs.
module mat_vec_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_STRIDE = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_read,
    input  logic                    mem_waitrequest,
    input  logic [8*DATA_WIDTH-1:0] mem_readdata,
    input  logic                    mem_readdatavalid,
    output logic                    clr,
    output logic                    a_wren,
    output logic [DATA_WIDTH-1:0]   a_fifo_in [7:0],
    output logic                    b_wren,
    output logic [DATA_WIDTH-1:0]   b_fifo_in
);

    localparam int WORD_W = 8 * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, CLR, FETCH, WRITE, DONE} state_t;

    state_t                state, state_nxt;
    logic [3:0]            issued, received;
    logic [2:0]            wcnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_W-1:0]     buf_q [9];
    logic                  accept, rvalid;

    assign accept = mem_read && !mem_waitrequest;
    // Responses only count while fetching; stale ones after an abort land in IDLE.
    assign rvalid = (state == FETCH) && mem_readdatavalid && (received < 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued   <= '0;
            received <= '0;
            wcnt     <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        issued   <= '0;
                        received <= '0;
                        wcnt     <= '0;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        issued <= issued + 4'd1;
                        addr_q <= addr_q + ADDR_WIDTH'(WORD_STRIDE);
                    end
                    if (rvalid) received <= received + 4'd1;
                end
                WRITE:   wcnt <= wcnt + 3'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rvalid) buf_q[received] <= mem_readdata;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLR;
            CLR:     state_nxt = FETCH;
            FETCH:   if (rvalid && received == 4'd8) state_nxt = WRITE;
            WRITE:   if (wcnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        clr       = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        a_wren    = 1'b0;
        b_wren    = 1'b0;
        b_fifo_in = '0;
        for (int r = 0; r < 8; r++) a_fifo_in[r] = '0;
        case (state)
            CLR: begin
                busy = 1'b1;
                clr  = 1'b1;
            end
            FETCH: begin
                busy     = 1'b1;
                mem_read = (issued < 4'd9);
                if (mem_read) mem_addr = addr_q;
            end
            WRITE: begin
                busy   = 1'b1;
                a_wren = 1'b1;
                b_wren = 1'b1;
                // Transpose: column wcnt of A is byte lane wcnt of every row word.
                for (int r = 0; r < 8; r++)
                    a_fifo_in[r] = buf_q[r][int'(wcnt)*DATA_WIDTH +: DATA_WIDTH];
                b_fifo_in = buf_q[8][int'(wcnt)*DATA_WIDTH +: DATA_WIDTH];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mat_vec_loader.sv
// Scoreboard bench for mat_vec_loader: a latency-modelled memory answers reads,
// expected addresses and column writes are queued at start and popped on output.
module tb_mat_vec_loader;
    localparam int DW = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, mem_read, clr, a_wren, b_wren;
    logic [AW-1:0] mem_addr;
    logic          mem_waitrequest = 1'b0;
    logic [63:0]   mem_readdata = '0;
    logic          mem_readdatavalid = 1'b0;
    logic [DW-1:0] a_fifo_in [7:0];
    logic [DW-1:0] b_fifo_in;

    mat_vec_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_STRIDE(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .clr(clr), .a_wren(a_wren),
        .a_fifo_in(a_fifo_in), .b_wren(b_wren), .b_fifo_in(b_fifo_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] apack();
        logic [63:0] v;
        for (int r = 0; r < 8; r++) v[r*8 +: 8] = a_fifo_in[r];
        return v;
    endfunction

    typedef struct { int due; logic [63:0] data; } resp_t;
    typedef struct { logic [63:0] a; logic [7:0] b; } wr_t;

    logic [63:0] mem [logic [31:0]];
    resp_t       pend [$];
    logic [31:0] exp_addr [$];
    wr_t         exp_wr [$];

    int cyc = 0;
    int t0 = 0;
    int last_due = 0;
    int lat_fix = 2;
    int lat_rand = 0;
    int stall_left = 0;
    int hold_cnt = 0;
    logic [31:0] hold_addr = '1;
    logic spur = 1'b0;
    int n_clr, n_rd, n_wr, n_done, clr_at, first_rd, last_rd, first_wr, last_wr, done_at, last_resp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        resp_t r;
        wr_t   w;
        int    rel, lat;
        rel = cyc - t0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            mem_readdatavalid = 1'b1;
            mem_readdata      = r.data;
            last_resp         = rel;
        end else if (spur) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = '1;
        end
        mem_waitrequest = 1'b0;
        if (mem_read && mem_addr == hold_addr) begin
            hold_cnt++;
            if (stall_left > 0) begin
                mem_waitrequest = 1'b1;
                stall_left--;
            end
        end
        if (mem_read && !mem_waitrequest) begin
            n_rd++;
            if (n_rd == 1) first_rd = rel;
            last_rd = rel;
            if (exp_addr.size() == 0) check_val("rd_extra", 1, 0);
            else check_val("rd_addr", mem_addr, exp_addr.pop_front());
            lat   = (lat_rand != 0) ? int'($urandom_range(6, 1)) : lat_fix;
            r.due = cyc + lat;
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            r.data   = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
            pend.push_back(r);
        end
        if (clr) begin
            n_clr++;
            clr_at = rel;
        end
        if (done) begin
            n_done++;
            done_at = rel;
        end
        if (a_wren) begin
            n_wr++;
            if (n_wr == 1) first_wr = rel;
            last_wr = rel;
            if (exp_wr.size() == 0) check_val("wr_extra", 1, 0);
            else begin
                w = exp_wr.pop_front();
                check_val("wr_a", apack(), w.a);
                check_val("wr_b", {b_wren, b_fifo_in}, {1'b1, w.b});
            end
        end
    end

    task automatic clear_stats();
        n_clr = 0; n_rd = 0; n_wr = 0; n_done = 0;
        clr_at = -1; first_rd = -1; last_rd = -1; first_wr = -1;
        last_wr = -1; done_at = -1; last_resp = -1;
    endtask

    // pat 0: A[r][c]=8r+c+1, b[j]=j+1; otherwise random words.
    task automatic launch(input logic [31:0] base, input int pat);
        logic [31:0] a;
        logic [63:0] wd, bw;
        wr_t         e;
        for (int k = 0; k < 9; k++) begin
            a = base + 32'(k * 8);
            for (int c = 0; c < 8; c++)
                wd[c*8 +: 8] = (k < 8) ? 8'(8 * k + c + 1) : 8'(c + 1);
            if (pat != 0) wd = {$urandom, $urandom};
            mem[a] = wd;
            exp_addr.push_back(a);
        end
        bw = mem[base + 32'd64];
        for (int w = 0; w < 8; w++) begin
            for (int r = 0; r < 8; r++) begin
                wd = mem[base + 32'(r * 8)];
                e.a[r*8 +: 8] = wd[w*8 +: 8];
            end
            e.b = bw[w*8 +: 8];
            exp_wr.push_back(e);
        end
        clear_stats();
        @(posedge clk); #1;
        base_addr = base;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0    = cyc - 1;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget && n_done == 0; i++) @(posedge clk);
        if (n_done == 0) check_val("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ctl", {busy, done, clr, mem_read, a_wren, b_wren}, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_a", apack(), 0);
        check_val("rst_b", b_fifo_in, 0);
        @(negedge clk) rst_n = 1'b1;

        // Spurious response in IDLE
        @(posedge clk); #1;
        spur = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        spur = 1'b0;
        check_val("spur_idle", {busy, mem_read, a_wren, done, clr}, 0);

        // Basic load, latency 2
        lat_fix = 2;
        launch(32'h100, 0);
        wait_done(200);
        check_val("basic_clr_n", n_clr, 1);
        check_val("basic_clr_at", clr_at, 1);
        check_val("basic_rd_first", first_rd, 2);
        check_val("basic_rd_last", last_rd, 10);
        check_val("basic_rd_n", n_rd, 9);
        check_val("basic_wr_first", first_wr, 13);
        check_val("basic_wr_last", last_wr, 20);
        check_val("basic_wr_n", n_wr, 8);
        check_val("basic_done_at", done_at, 21);
        check_val("basic_busy_end", busy, 0);

        // Waitrequest on read k=4 for 3 cycles
        hold_addr = 32'h120; stall_left = 3; hold_cnt = 0;
        launch(32'h100, 0);
        wait_done(200);
        check_val("stall_hold", hold_cnt, 4);
        check_val("stall_rd_n", n_rd, 9);
        check_val("stall_wr_n", n_wr, 8);
        hold_addr = '1;

        // Random latency, address wrap
        lat_rand = 1;
        launch(32'hFFFF_FFE0, 1);
        wait_done(300);
        check_val("varlat_first_wr", first_wr, last_resp + 1);
        check_val("varlat_wr_n", n_wr, 8);
        lat_rand = 0;

        // Start while busy is ignored
        lat_fix = 3;
        launch(32'h400, 1);
        repeat (3) @(posedge clk);
        #1;
        base_addr = 32'h9000;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        repeat (30) @(posedge clk);
        check_val("busy_start_rd_n", n_rd, 9);
        check_val("busy_start_wr_n", n_wr, 8);
        check_val("busy_start_done_n", n_done, 1);

        // Reset in the middle of WRITE
        launch(32'h200, 1);
        for (int i = 0; i < 200 && n_wr < 4; i++) @(posedge clk);
        check_val("midwr_reached", n_wr, 4);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midwr_rst_ctl", {busy, done, clr, mem_read, a_wren, b_wren}, 0);
        check_val("midwr_rst_a", apack(), 0);
        check_val("midwr_rst_b", b_fifo_in, 0);
        exp_wr.delete();
        exp_addr.delete();
        n_wr = 0; n_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check_val("midwr_no_done", n_done, 0);
        check_val("midwr_no_wr", n_wr, 0);
        launch(32'h200, 0);
        wait_done(200);
        check_val("fresh_wr_n", n_wr, 8);
        check_val("fresh_done_n", n_done, 1);
        check_val("fresh_q_empty", exp_wr.size() + exp_addr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mat_vec_loader.md
Name: mat_vec_loader

Overview:
- Memory-side producer for the 8x8 matrix-vector multiply unit.
- On start, clears the MAC accumulators and fetches the 8x8 matrix A (row-major, one row per memory word) plus vector b (one word) over a pipelined read-master interface.
- Buffers all nine words, transposes them, and emits eight column-wise FIFO writes that fill the unit's A-row FIFOs and B FIFO.
- The multiply unit starts itself once every FIFO is full.

Parameters:
- DATA_WIDTH, 8, element width; memory word width is 8*DATA_WIDTH.
- ADDR_WIDTH, 32, byte address width.
- WORD_STRIDE, 8, byte address increment between consecutive words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  byte address of A row 0; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last FIFO write.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  request not accepted this cycle.
- mem_readdata  in  8*DATA_WIDTH  read data; byte lane j = element j.
- mem_readdatavalid  in  1  response valid; responses return in order.
- clr  out  1  accumulator clear pulse to the multiply unit.
- a_wren  out  1  A FIFO write enable.
- a_fifo_in  out  8 x DATA_WIDTH (unpacked [7:0])  A elements, one per row FIFO.
- b_wren  out  1  B FIFO write enable.
- b_fifo_in  out  DATA_WIDTH  b element.

Behaviour:
- Reset values: all outputs 0 (busy, done, clr, mem_read, mem_addr, a_wren, a_fifo_in, b_wren, b_fifo_in). State = IDLE. Counters = 0.
- States and transitions:
  - IDLE: start=1 captures base_addr and goes to CLR. start while not in IDLE is ignored.
  - CLR: one cycle. clr=1, busy=1. Then FETCH.
  - FETCH: issues 9 reads at base_addr + k*WORD_STRIDE, k=0..8. Words 0..7 are A rows; word 8 is b.
    - mem_read=1 while issued<9.
    - A request is accepted when mem_read && !mem_waitrequest. On acceptance, issued increments and mem_addr advances the next cycle.
    - While waitrequest=1, mem_addr and mem_read are held stable.
    - No outstanding-read limit.
    - Each mem_readdatavalid stores mem_readdata into buffer slot received, then received increments.
    - Acceptance and response in the same cycle both update their counters.
    - When received reaches 9, the next state is WRITE.
  - WRITE: eight consecutive cycles, w=0..7, with no gaps.
    - a_wren=b_wren=1.
    - a_fifo_in[r] = row r byte lane w (A[r][w]).
    - b_fifo_in = b byte lane w.
    - After w=7, go to DONE.
  - DONE: one cycle. done=1, busy=0. Then IDLE.
- Outside WRITE, a_wren and b_wren are 0 and a_fifo_in/b_fifo_in are 0.
- Latency: with no waitrequest and fixed read latency L, a start sampled at edge 0 produces:
  - clr in cycle 1;
  - reads in cycles 2..10;
  - writes in cycles 11+L .. 18+L;
  - done in cycle 19+L.
- Boundaries:
  - mem_readdatavalid outside FETCH is ignored and does not alter the buffers.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - Asserting rst_n low in any state returns immediately to IDLE with reset output values. No write or done is emitted for the aborted job.
  - Responses still in flight from an aborted job that arrive after reset are ignored, because the block is in IDLE.
  - The block does not check FIFO full. Sequencing start only after the previous multiply completes is the responsibility of the upper level.

Test Plan:
- Basic load: A[r][c]=8r+c+1, b[j]=j+1, base_addr=0x100, memory latency 2, no waitrequest.
  - -> reads at 0x100..0x140 step 8 in cycles 2..10.
  - -> writes in cycles 13..20, with write w carrying a_fifo_in[r]=8r+w+1 and b_fifo_in=w+1.
  - -> done in cycle 21; clr only in cycle 1.
- Waitrequest stall: waitrequest=1 for 3 cycles on read k=4.
  - -> mem_addr held at base+0x20 with mem_read=1 for those cycles; no address skipped; write data unchanged from the basic case.
- Variable latency: random latencies 1..6 with back-to-back issue.
  - -> every buffered row matches its address; first write occurs exactly 1 cycle after the 9th response.
- Start while busy: pulse start during FETCH with a different base_addr.
  - -> ignored; addresses continue from the original base; exactly 8 writes and one done.
- Reset mid-WRITE: assert rst_n low after write w=3.
  - -> all outputs 0 immediately; no done.
  - -> a new start afterwards performs a full fresh load with 8 writes.
- Spurious response: mem_readdatavalid=1 with data 0xFF.. while in IDLE.
  - -> no state change; the subsequent basic load produces the expected values.
